// File: rtl/mac_array_pkg.sv
// Shared definitions for the 3x3 MAC array controller:
// FSM encoding, pe_en bit layout and default array limits.
package mac_array_pkg;

  localparam int DEF_MAX_W    = 56;
  localparam int DEF_MAX_H    = 56;
  localparam int DEF_MAX_CG   = 2;
  localparam int DEF_MAX_CO   = 64;
  localparam int DEF_PIPE_LAT = 6;
  localparam int DEF_ID_W     = 5;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_CONV  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam int PE_ID_BIT = 9;

  // Tap (kr,kc) of the 3x3 window; (0,0) is the top-left tap.
  function automatic int tap_idx(
    input int kr,
    input int kc
  );
    return 8 - 3 * kr - kc;
  endfunction

endpackage

// File: rtl/mac_vld_pipe.sv
// Enable-gated shift register that keeps the valid/info
// stream aligned with the MAC array latency.
module mac_vld_pipe #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
    end else if (en) begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/mac_array_ctrl.sv
// Job controller for the 3x3 MAC array: imap read sequencing,
// compute position walk, border tap masks and psum output stream.
module mac_array_ctrl
  import mac_array_pkg::*;
#(
  parameter int MAX_W    = DEF_MAX_W,
  parameter int MAX_H    = DEF_MAX_H,
  parameter int MAX_CG   = DEF_MAX_CG,
  parameter int MAX_CO   = DEF_MAX_CO,
  parameter int PIPE_LAT = DEF_PIPE_LAT,
  parameter int ID_W     = DEF_ID_W,
  localparam int WD    = $clog2(MAX_W + 1),
  localparam int HD    = $clog2(MAX_H + 1),
  localparam int PIX_W = $clog2(MAX_W * MAX_H),
  localparam int CG_W  = (MAX_CG > 2) ? $clog2(MAX_CG) : 1,
  localparam int CO_W  = $clog2(MAX_CO)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      conv_start,
  input  logic [WD-1:0]             cfg_w,
  input  logic [HD-1:0]             cfg_h,
  input  logic [CG_W:0]             cfg_cg,
  input  logic [CO_W:0]             cfg_co,
  input  logic                      mac_array2psum_acc_rdy,
  output logic                      busy,
  output logic                      cfg_err,
  output logic                      conv_done,
  output logic                      pipe_en,
  output logic [9:0]                pe_en,
  output logic [CG_W:0]             weight_sel,
  output logic                      imap_ren,
  output logic [CG_W+PIX_W-1:0]     imap_raddr,
  output logic                      mac_array2psum_acc_vld,
  output logic [CO_W+CG_W+PIX_W-1:0] mac_array2psum_acc_info,
  output logic [ID_W-1:0]           identity_sel,
  output logic [CO_W-1:0]           out_ch_cnt,
  output logic [CG_W-1:0]           in_grp_cnt
);

  localparam int CGN    = CG_W + 1;
  localparam int CON    = CO_W + 1;
  localparam int INFO_W = CO_W + CG_W + PIX_W;
  localparam int TOT_W  = $clog2(MAX_W * MAX_H * MAX_CG * MAX_CO + 1);

  localparam logic [WD-1:0]  W_LO  = WD'(3);
  localparam logic [WD-1:0]  W_HI  = WD'(MAX_W);
  localparam logic [HD-1:0]  H_LO  = HD'(3);
  localparam logic [HD-1:0]  H_HI  = HD'(MAX_H);
  localparam logic [CGN-1:0] CG_HI = CGN'(MAX_CG);
  localparam logic [CON-1:0] CO_HI = CON'(MAX_CO);

  logic [1:0]       state;
  logic [WD-1:0]    w_q;
  logic [HD-1:0]    h_q;
  logic [CG_W:0]    cg_q;
  logic [CO_W:0]    co_q;
  logic [PIX_W:0]   plane_q;
  logic [TOT_W-1:0] total_q;
  logic [WD:0]      setup_cnt;
  logic [TOT_W-1:0] rd_cnt;
  logic [TOT_W-1:0] hs_cnt;
  logic [CG_W-1:0]  rd_grp;
  logic [PIX_W-1:0] rd_pix;
  logic [WD-1:0]    col;
  logic [HD-1:0]    row;
  logic [PIX_W-1:0] pix;
  logic [CG_W-1:0]  grp;
  logic [CO_W-1:0]  oc;
  logic             done_q;
  logic             err_q;

  logic cfg_ok;
  logic start_ok;
  logic in_conv;
  logic in_rd;
  logic hs;
  logic col_last;
  logic row_last;
  logic grp_last;
  logic oc_last;
  logic plane_end;
  logic rd_pix_last;
  logic rd_grp_last;
  logic setup_last;
  logic hs_last;

  assign cfg_ok = (cfg_w >= W_LO) && (cfg_w <= W_HI)
               && (cfg_h >= H_LO) && (cfg_h <= H_HI)
               && (cfg_cg != '0) && (cfg_cg <= CG_HI)
               && (cfg_co != '0) && (cfg_co <= CO_HI);

  assign start_ok = (state == S_IDLE) && conv_start && cfg_ok;
  assign busy     = (state != S_IDLE);
  assign pipe_en  = busy && mac_array2psum_acc_rdy;
  assign in_conv  = (state == S_CONV);
  assign in_rd    = (state == S_SETUP) || in_conv;
  assign hs       = mac_array2psum_acc_vld && pipe_en;

  assign col_last    = (col == w_q - 1'b1);
  assign row_last    = (row == h_q - 1'b1);
  assign grp_last    = ({1'b0, grp} == cg_q - 1'b1);
  assign oc_last     = ({1'b0, oc} == co_q - 1'b1);
  assign plane_end   = col_last && row_last;
  assign rd_pix_last = ({1'b0, rd_pix} == plane_q - 1'b1);
  assign rd_grp_last = ({1'b0, rd_grp} == cg_q - 1'b1);
  assign setup_last  = (setup_cnt == {1'b0, w_q} + 1'b1);
  assign hs_last     = (hs_cnt == total_q - 1'b1);

  assign imap_ren = pipe_en && in_rd && (rd_cnt < total_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      w_q       <= '0;
      h_q       <= '0;
      cg_q      <= '0;
      co_q      <= '0;
      plane_q   <= '0;
      total_q   <= '0;
      setup_cnt <= '0;
      hs_cnt    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (conv_start && cfg_ok) begin
            w_q       <= cfg_w;
            h_q       <= cfg_h;
            cg_q      <= cfg_cg;
            co_q      <= cfg_co;
            plane_q   <= (PIX_W+1)'(cfg_w) * (PIX_W+1)'(cfg_h);
            total_q   <= TOT_W'(cfg_w) * TOT_W'(cfg_h)
                       * TOT_W'(cfg_cg) * TOT_W'(cfg_co);
            setup_cnt <= '0;
            hs_cnt    <= '0;
            state     <= S_SETUP;
          end else if (conv_start) begin
            err_q <= 1'b1;
          end
        end
        S_SETUP: begin
          if (pipe_en) begin
            setup_cnt <= setup_cnt + 1'b1;
            if (setup_last) state <= S_CONV;
          end
        end
        S_CONV: begin
          if (pipe_en && plane_end && grp_last && oc_last)
            state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (hs && hs_last) begin
            state  <= S_IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
      // Beats also land during CONV once the pipe has filled.
      if (hs) hs_cnt <= hs_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt <= '0;
      rd_pix <= '0;
      rd_grp <= '0;
    end else if (start_ok) begin
      rd_cnt <= '0;
      rd_pix <= '0;
      rd_grp <= '0;
    end else if (imap_ren) begin
      rd_cnt <= rd_cnt + 1'b1;
      if (rd_pix_last) begin
        rd_pix <= '0;
        rd_grp <= rd_grp_last ? '0 : rd_grp + 1'b1;
      end else begin
        rd_pix <= rd_pix + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
      pix <= '0;
      grp <= '0;
      oc  <= '0;
    end else if (start_ok) begin
      col <= '0;
      row <= '0;
      pix <= '0;
      grp <= '0;
      oc  <= '0;
    end else if (pipe_en && in_conv) begin
      col <= col_last ? '0 : col + 1'b1;
      pix <= plane_end ? '0 : pix + 1'b1;
      if (col_last) row <= row_last ? '0 : row + 1'b1;
      if (plane_end) begin
        if (grp_last) begin
          grp <= '0;
          oc  <= oc_last ? '0 : oc + 1'b1;
        end else begin
          grp <= grp + 1'b1;
        end
      end
    end
  end

  always_comb begin
    pe_en = '0;
    if (in_conv) begin
      pe_en[PE_ID_BIT] = 1'b1;
      for (int kr = 0; kr < 3; kr++) begin
        for (int kc = 0; kc < 3; kc++) begin
          pe_en[4'(tap_idx(kr, kc))] =
            !((kr == 0 && row == '0) || (kr == 2 && row_last)
           || (kc == 0 && col == '0) || (kc == 2 && col_last));
        end
      end
    end
  end

  mac_vld_pipe #(
    .WIDTH (1 + INFO_W),
    .DEPTH (PIPE_LAT)
  ) u_vld_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pipe_en),
    .d     ({in_conv, oc, grp, pix}),
    .q     ({mac_array2psum_acc_vld, mac_array2psum_acc_info})
  );

  assign conv_done    = done_q;
  assign cfg_err      = err_q;
  assign weight_sel   = {oc[0], grp};
  assign imap_raddr   = {rd_grp, rd_pix};
  assign identity_sel = oc[ID_W-1:0];
  assign out_ch_cnt   = oc;
  assign in_grp_cnt   = grp;

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Scoreboard bench for mac_array_ctrl: expected beats, reads and
// compute positions are queued at job start and popped by a monitor.
module tb_mac_array_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        conv_start = 1'b0;
  logic [5:0]  cfg_w = '0;
  logic [5:0]  cfg_h = '0;
  logic [1:0]  cfg_cg = '0;
  logic [6:0]  cfg_co = '0;
  logic        acc_rdy = 1'b1;
  logic        busy, cfg_err, conv_done, pipe_en;
  logic [9:0]  pe_en;
  logic [1:0]  weight_sel;
  logic        imap_ren;
  logic [12:0] imap_raddr;
  logic        acc_vld;
  logic [18:0] acc_info;
  logic [4:0]  identity_sel;
  logic [5:0]  out_ch_cnt;
  logic        in_grp_cnt;

  mac_array_ctrl dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .conv_start              (conv_start),
    .cfg_w                   (cfg_w),
    .cfg_h                   (cfg_h),
    .cfg_cg                  (cfg_cg),
    .cfg_co                  (cfg_co),
    .mac_array2psum_acc_rdy  (acc_rdy),
    .busy                    (busy),
    .cfg_err                 (cfg_err),
    .conv_done               (conv_done),
    .pipe_en                 (pipe_en),
    .pe_en                   (pe_en),
    .weight_sel              (weight_sel),
    .imap_ren                (imap_ren),
    .imap_raddr              (imap_raddr),
    .mac_array2psum_acc_vld  (acc_vld),
    .mac_array2psum_acc_info (acc_info),
    .identity_sel            (identity_sel),
    .out_ch_cnt              (out_ch_cnt),
    .in_grp_cnt              (in_grp_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [9:0] pe;
    logic [4:0] id;
    logic [1:0] ws;
    logic [5:0] oc;
    logic       grp;
  } cexp_t;

  logic [18:0] q_info [$];
  logic [12:0] q_rd [$];
  cexp_t       q_cmp [$];
  logic [9:0]  pe_log [$];

  int   n_vec = 0;
  int   n_err = 0;
  int   n_beats = 0;
  int   last_hs = 0;
  bit   rand_rdy = 1'b0;
  logic prev_stall = 1'b0;
  logic [18:0] prev_info = '0;

  logic [9:0] pe_tab [9] = '{10'h21B, 10'h23F, 10'h236,
                             10'h2DB, 10'h3FF, 10'h3B6,
                             10'h2D8, 10'h3F8, 10'h3B0};

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    acc_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin : mon
    cexp_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_vld", acc_vld, 1);
        chk("hold_info", acc_info, prev_info);
      end
      if (acc_vld && acc_rdy) begin
        n_beats++;
        last_hs = cyc;
        if (q_info.size() == 0) chk("extra_beat", 1, 0);
        else chk("info", acc_info, q_info.pop_front());
      end
      if (imap_ren) begin
        if (q_rd.size() == 0) chk("extra_read", 1, 0);
        else chk("raddr", imap_raddr, q_rd.pop_front());
      end
      if (pipe_en && pe_en[9]) begin
        pe_log.push_back(pe_en);
        if (q_cmp.size() == 0) begin
          chk("extra_pixel", 1, 0);
        end else begin
          e = q_cmp.pop_front();
          chk("pe_en", pe_en, e.pe);
          chk("identity_sel", identity_sel, e.id);
          chk("weight_sel", weight_sel, e.ws);
          chk("out_ch_cnt", out_ch_cnt, e.oc);
          chk("in_grp_cnt", in_grp_cnt, e.grp);
        end
      end
      prev_stall = acc_vld && !acc_rdy;
      prev_info  = acc_info;
    end
  end

  task automatic push_exp(input int w, input int h,
                          input int cg, input int co);
    cexp_t e;
    int    pix;
    for (int o = 0; o < co; o++)
      for (int g = 0; g < cg; g++)
        for (int r = 0; r < h; r++)
          for (int c = 0; c < w; c++) begin
            pix = r * w + c;
            q_info.push_back({6'(o), 1'(g), 12'(pix)});
            q_rd.push_back({1'(g), 12'(pix)});
            e.pe = 10'h200;
            for (int kr = 0; kr < 3; kr++)
              for (int kc = 0; kc < 3; kc++)
                if (!((kr == 0 && r == 0) || (kr == 2 && r == h - 1)
                   || (kc == 0 && c == 0) || (kc == 2 && c == w - 1)))
                  e.pe[8 - 3 * kr - kc] = 1'b1;
            e.id  = 5'(o);
            e.ws  = {1'(o), 1'(g)};
            e.oc  = 6'(o);
            e.grp = 1'(g);
            q_cmp.push_back(e);
          end
  endtask

  task automatic start_job(input int w, input int h,
                           input int cg, input int co,
                           output int s0);
    push_exp(w, h, cg, co);
    n_beats    = 0;
    cfg_w      = 6'(w);
    cfg_h      = 6'(h);
    cfg_cg     = 2'(cg);
    cfg_co     = 7'(co);
    conv_start = 1'b1;
    s0         = cyc;
    @(posedge clk);
    #1;
    conv_start = 1'b0;
  endtask

  task automatic finish_job(input int beats, input int s0,
                            input int exp_cyc, input int budget);
    bit got;
    int dc;
    got = 1'b0;
    dc  = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (conv_done) begin
        got = 1'b1;
        dc  = cyc;
      end
    end
    if (!got) begin
      chk("done_timeout", 0, 1);
    end else begin
      chk("done_lat", dc - last_hs, 1);
      chk("busy_at_done", busy, 0);
      chk("beats", n_beats, beats);
      chk("info_left", q_info.size(), 0);
      chk("rd_left", q_rd.size(), 0);
      chk("pix_left", q_cmp.size(), 0);
      if (exp_cyc > 0) chk("cycles", dc - s0, exp_cyc);
    end
  endtask

  task automatic bad_start(input string name,
                           input int w, input int h,
                           input int cg, input int co);
    cfg_w      = 6'(w);
    cfg_h      = 6'(h);
    cfg_cg     = 2'(cg);
    cfg_co     = 7'(co);
    conv_start = 1'b1;
    @(posedge clk);
    #1;
    conv_start = 1'b0;
    chk({name, "_err"}, cfg_err, 1);
    chk({name, "_busy"}, busy, 0);
    @(posedge clk);
    #1;
    chk({name, "_err_clr"}, cfg_err, 0);
    chk({name, "_idle"}, busy, 0);
  endtask

  function automatic logic [63:0] all_outs();
    return {busy, cfg_err, conv_done, pipe_en, pe_en, weight_sel,
            imap_ren, imap_raddr, acc_vld, acc_info,
            identity_sel, out_ch_cnt, in_grp_cnt};
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, s1;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", all_outs(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_outs", all_outs(), 0);

    bad_start("w2", 2, 5, 1, 1);
    bad_start("co0", 5, 5, 1, 0);
    bad_start("w57", 57, 5, 1, 1);
    bad_start("cg3", 5, 5, 3, 1);
    bad_start("h2", 5, 2, 1, 1);

    pe_log.delete();
    start_job(3, 3, 1, 1, s0);
    finish_job(9, s0, 21, 200);
    chk("pe_log_len", pe_log.size(), 9);
    for (int i = 0; i < 9 && i < pe_log.size(); i++)
      chk($sformatf("pe_tab%0d", i), pe_log[i], pe_tab[i]);
    chk("pe_idle", pe_en, 0);

    start_job(3, 3, 1, 64, s0);
    finish_job(576, s0, 588, 1000);

    rand_rdy = 1'b1;
    start_job(4, 3, 2, 3, s0);
    finish_job(72, s0, 0, 2000);
    rand_rdy = 1'b0;

    start_job(4, 3, 1, 2, s0);
    repeat (10) @(posedge clk);
    #1;
    cfg_w      = 6'd3;
    cfg_h      = 6'd3;
    cfg_co     = 7'd1;
    conv_start = 1'b1;
    @(posedge clk);
    #1;
    conv_start = 1'b0;
    finish_job(24, s0, 37, 300);
    start_job(3, 3, 1, 1, s1);
    finish_job(9, s1, 21, 200);

    start_job(56, 56, 2, 1, s0);
    finish_job(6272, s0, 6337, 8000);

    start_job(5, 5, 1, 1, s0);
    repeat (16) @(posedge clk);
    #1;
    chk("pre_rst_vld", acc_vld, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", all_outs(), 0);
    q_info.delete();
    q_rd.delete();
    q_cmp.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_outs", all_outs(), 0);
    start_job(5, 5, 2, 2, s0);
    finish_job(100, s0, 114, 400);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
